// File: rtl/rv_mem_resp.sv
// Multicycle word-memory responder: accepts one read/write, waits WAIT_CYCLES,
// then closes the access with a one-cycle ready pulse (err on faulted access).
module rv_mem_resp #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = (WAIT_CYCLES == 0) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = (WAIT_CYCLES == 0) ? '0 : CW'(WAIT_CYCLES - 1);
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_capture;

  logic [31:0]   r_addr;
  logic          r_we;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          r_ready;
  logic          r_err;
  logic          r_busy;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic [31:0]   w_acc_addr;
  logic          w_acc_we;
  logic          w_acc_fault;
  logic [31:0]   w_rd_word;
  logic          w_wr_en;

  function automatic logic is_fault(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({1'b0, a} >= ADDR_LIMIT);
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_capture   = 1'b1;
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // With zero wait states RESP is entered on the accepting edge, so the read
  // must use the live request instead of the not-yet-loaded request registers.
  assign w_acc_addr  = w_capture ? addr : r_addr;
  assign w_acc_we    = w_capture ? we : r_we;
  assign w_acc_fault = is_fault(w_acc_addr);
  assign w_rd_word   = r_mem[w_acc_addr[2 +: AW]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_capture) begin
        r_addr  <= addr;
        r_we    <= we;
        r_wdata <= wdata;
      end
      r_ready <= (w_state_nxt == S_RESP);
      r_err   <= (w_state_nxt == S_RESP) && w_acc_fault;
      r_busy  <= (w_state_nxt != S_IDLE);
      if ((w_state_nxt == S_RESP) && !w_acc_we) begin
        r_rdata <= w_acc_fault ? '0 : w_rd_word;
      end
    end
  end

  // Reset forces IDLE asynchronously, so RESP (and hence a write) cannot be
  // live at a clock edge while rst is held.
  assign w_wr_en = (r_state == S_RESP) && r_we && !is_fault(r_addr);

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_addr[2 +: AW]] <= r_wdata;
    end
  end

  assign rdata = r_rdata;
  assign ready = r_ready;
  assign err   = r_err;
  assign busy  = r_busy;

endmodule

// File: tb/tb_rv_mem_resp.sv
// Bench for rv_mem_resp: directed scenarios plus randomized accesses checked
// against an associative-array memory model (WAIT_CYCLES=2 and WAIT_CYCLES=0).
`timescale 1ns/1ps
module tb_rv_mem_resp;

  localparam int unsigned DEPTH = 1024;
  localparam int          LAT2  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we, req0, we0;
  logic [31:0] addr, wdata, addr0, wdata0;
  logic [31:0] rdata, rdata0;
  logic        ready, err, busy, ready0, err0, busy0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem2 [int unsigned];
  logic [31:0] mem0 [int unsigned];

  rv_mem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .err(err), .busy(busy)
  );

  rv_mem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ready(ready0), .err(err0), .busy(busy0)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic model_fault(input logic [31:0] a);
    return (a % 4 != 0) || (a >= DEPTH * 4);
  endfunction

  // Drives one access on the WAIT_CYCLES=2 instance and reports what was seen.
  task automatic access2(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input bit drop_mid, input logic [31:0] alt_a,
                         output int lat, output logic [31:0] rd, output logic e,
                         output int busy_n, output logic ready_after);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    lat = -1; busy_n = 0; rd = '0; e = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (ready) begin
        lat = n; rd = rdata; e = err;
        break;
      end
      if (n == 1 && drop_mid) begin
        req = 1'b0; addr = alt_a; we = ~w; wdata = ~d;
      end
    end
    req = 1'b0;
    @(negedge clk);
    if (busy) busy_n++;
    ready_after = ready;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b expected 0", ready); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    n_cmp++; if ({ready0, err0, busy0} !== 3'b000) begin n_bad++; $display("FAIL reset_w0_flags: got %b expected 000", {ready0, err0, busy0}); end
    n_cmp++; if (rdata0 !== 32'h0) begin n_bad++; $display("FAIL reset_w0_rdata: got %h expected 0", rdata0); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    int lat, bn; logic [31:0] rd; logic e, ra;
    access2(32'h10, 1'b1, 32'hDEADBEEF, 1'b0, '0, lat, rd, e, bn, ra);
    mem2[32'h10 / 4] = 32'hDEADBEEF;
    n_cmp++; if (lat != LAT2) begin n_bad++; $display("FAIL wr_latency: got %0d expected %0d", lat, LAT2); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL wr_err: got %b expected 0", e); end
    n_cmp++; if (bn != LAT2) begin n_bad++; $display("FAIL wr_busy_cycles: got %0d expected %0d", bn, LAT2); end
    n_cmp++; if (ra !== 1'b0) begin n_bad++; $display("FAIL wr_ready_pulse: got %b expected 0 after pulse", ra); end
    access2(32'h10, 1'b0, 32'h0, 1'b0, '0, lat, rd, e, bn, ra);
    n_cmp++; if (lat != LAT2) begin n_bad++; $display("FAIL rd_latency: got %0d expected %0d", lat, LAT2); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL rd_err: got %b expected 0", e); end
    n_cmp++; if (bn != LAT2) begin n_bad++; $display("FAIL rd_busy_cycles: got %0d expected %0d", bn, LAT2); end
  endtask

  task automatic test_misaligned;
    int lat, bn; logic [31:0] rd; logic e, ra;
    access2(32'h20, 1'b1, 32'h0BADF00D, 1'b0, '0, lat, rd, e, bn, ra);
    mem2[32'h20 / 4] = 32'h0BADF00D;
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL mis_setup_err: got %b expected 0", e); end
    access2(32'h22, 1'b1, 32'h12345678, 1'b0, '0, lat, rd, e, bn, ra);
    n_cmp++; if (lat != LAT2) begin n_bad++; $display("FAIL mis_latency: got %0d expected %0d", lat, LAT2); end
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL mis_err: got %b expected 1", e); end
    access2(32'h20, 1'b0, 32'h0, 1'b0, '0, lat, rd, e, bn, ra);
    n_cmp++; if (rd !== mem2[32'h20 / 4]) begin n_bad++; $display("FAIL mis_readback: got %h expected %h", rd, mem2[32'h20 / 4]); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL mis_readback_err: got %b expected 0", e); end
  endtask

  task automatic test_out_of_range;
    int lat, bn; logic [31:0] rd, v; logic e, ra;
    access2(32'h1000, 1'b0, 32'h0, 1'b0, '0, lat, rd, e, bn, ra);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL oor_err: got %b expected 1", e); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL oor_rdata: got %h expected 0", rd); end
    n_cmp++; if (lat != LAT2) begin n_bad++; $display("FAIL oor_latency: got %0d expected %0d", lat, LAT2); end
    v = $urandom;
    access2(32'hFFC, 1'b1, v, 1'b0, '0, lat, rd, e, bn, ra);
    mem2[32'hFFC / 4] = v;
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL top_wr_err: got %b expected 0", e); end
    access2(32'hFFC, 1'b0, 32'h0, 1'b0, '0, lat, rd, e, bn, ra);
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL top_rd_err: got %b expected 0", e); end
    n_cmp++; if (rd !== v) begin n_bad++; $display("FAIL top_rd_data: got %h expected %h", rd, v); end
  endtask

  task automatic test_req_drop;
    int lat, bn; logic [31:0] rd, v, w8; logic e, ra;
    w8 = $urandom; v = $urandom;
    access2(32'h8, 1'b1, w8, 1'b0, '0, lat, rd, e, bn, ra);
    mem2[32'h8 / 4] = w8;
    access2(32'h40, 1'b1, v, 1'b1, 32'h8, lat, rd, e, bn, ra);
    mem2[32'h40 / 4] = v;
    n_cmp++; if (lat != LAT2) begin n_bad++; $display("FAIL drop_wr_latency: got %0d expected %0d", lat, LAT2); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL drop_wr_err: got %b expected 0", e); end
    access2(32'h40, 1'b0, 32'h0, 1'b1, 32'h8, lat, rd, e, bn, ra);
    n_cmp++; if (lat != LAT2) begin n_bad++; $display("FAIL drop_rd_latency: got %0d expected %0d", lat, LAT2); end
    n_cmp++; if (rd !== v) begin n_bad++; $display("FAIL drop_rd_data: got %h expected %h", rd, v); end
    access2(32'h8, 1'b0, 32'h0, 1'b0, '0, lat, rd, e, bn, ra);
    n_cmp++; if (rd !== w8) begin n_bad++; $display("FAIL drop_alt_untouched: got %h expected %h", rd, w8); end
  endtask

  task automatic test_back_to_back_w0;
    logic [31:0] oa[$], od[$];
    logic        exp_r;
    int          op, seen;
    oa.push_back(32'h4); od.push_back(32'hA5A5A5A5);
    for (int i = 0; i < 5; i++) begin
      oa.push_back($urandom_range(0, DEPTH - 1) * 4);
      od.push_back($urandom);
    end
    op = 0; seen = 0;
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = oa[0]; wdata0 = od[0];
    for (int k = 1; k <= 2 * 2 * oa.size(); k++) begin
      @(negedge clk);
      exp_r = (k % 2 == 1);
      n_cmp++; if (ready0 !== exp_r) begin n_bad++; $display("FAIL b2b_ready_%0d: got %b expected %b", k, ready0, exp_r); end
      n_cmp++; if (busy0 !== exp_r) begin n_bad++; $display("FAIL b2b_busy_%0d: got %b expected %b", k, busy0, exp_r); end
      if (ready0 === 1'b1) begin
        seen++;
        n_cmp++; if (err0 !== 1'b0) begin n_bad++; $display("FAIL b2b_err_%0d: got %b expected 0", op, err0); end
        if (op % 2 == 0) begin
          mem0[oa[op / 2] / 4] = od[op / 2];
        end else begin
          n_cmp++; if (rdata0 !== mem0[oa[op / 2] / 4]) begin n_bad++; $display("FAIL b2b_rdata_%0d: got %h expected %h", op, rdata0, mem0[oa[op / 2] / 4]); end
        end
        op++;
        if (op < 2 * oa.size()) begin
          we0 = (op % 2 == 0); addr0 = oa[op / 2]; wdata0 = od[op / 2];
        end else begin
          req0 = 1'b0;
        end
      end
    end
    req0 = 1'b0;
    n_cmp++; if (seen != 2 * oa.size()) begin n_bad++; $display("FAIL b2b_count: got %0d expected %0d", seen, 2 * oa.size()); end
  endtask

  task automatic test_reset_mid;
    int lat, bn, nready; logic [31:0] rd; logic e, ra;
    access2(32'h30, 1'b1, 32'h11223344, 1'b0, '0, lat, rd, e, bn, ra);
    mem2[32'h30 / 4] = 32'h11223344;
    for (int ph = 1; ph <= LAT2; ph += LAT2 - 1) begin
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'h55 + ph;
      repeat (ph) @(negedge clk);
      n_cmp++; if (ready !== (ph == LAT2)) begin n_bad++; $display("FAIL rstmid_pre_ready_ph%0d: got %b expected %b", ph, ready, ph == LAT2); end
      rst = 1'b1;
      #1;
      n_cmp++; if ({ready, err, busy} !== 3'b000) begin n_bad++; $display("FAIL rstmid_flags_ph%0d: got %b expected 000", ph, {ready, err, busy}); end
      n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rstmid_rdata_ph%0d: got %h expected 0", ph, rdata); end
      req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      nready = 0;
      repeat (6) begin
        @(negedge clk);
        if (ready) nready++;
      end
      n_cmp++; if (nready != 0) begin n_bad++; $display("FAIL rstmid_no_ready_ph%0d: got %0d pulses expected 0", ph, nready); end
      access2(32'h30, 1'b0, 32'h0, 1'b0, '0, lat, rd, e, bn, ra);
      n_cmp++; if (rd !== 32'h11223344) begin n_bad++; $display("FAIL rstmid_readback_ph%0d: got %h expected 11223344", ph, rd); end
    end
  endtask

  task automatic test_random;
    int lat, bn, kind; logic [31:0] a, d, rd; logic w, e, ra, ef;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0)      a = $urandom_range(0, 15) * 4 + $urandom_range(1, 3);
      else if (kind == 1) a = DEPTH * 4 + $urandom_range(0, 32'h00FF_FFFF);
      else                a = $urandom_range(0, 15) * 4;
      w = $urandom_range(0, 1);
      d = $urandom;
      ef = model_fault(a);
      access2(a, w, d, 1'b0, '0, lat, rd, e, bn, ra);
      n_cmp++; if (lat != LAT2) begin n_bad++; $display("FAIL rnd_latency_%0d: got %0d expected %0d", i, lat, LAT2); end
      n_cmp++; if (e !== ef) begin n_bad++; $display("FAIL rnd_err_%0d: addr %h got %b expected %b", i, a, e, ef); end
      if (!w && ef) begin
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rnd_fault_rdata_%0d: got %h expected 0", i, rd); end
      end else if (!w && mem2.exists(a / 4)) begin
        n_cmp++; if (rd !== mem2[a / 4]) begin n_bad++; $display("FAIL rnd_rdata_%0d: addr %h got %h expected %h", i, a, rd, mem2[a / 4]); end
      end
      if (w && !ef) mem2[a / 4] = d;
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_misaligned;
    test_out_of_range;
    test_req_drop;
    test_back_to_back_w0;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv_mem_resp.md
# rv_mem_resp

Multicycle memory responder for the simple multicycle RISC-V model. It sits on the memory side of the control plane's memory access and serves word reads and writes from an internal word array. Each access completes after a programmable number of wait states and is closed by a one-cycle `ready` pulse. It gives the core a realistic slow-memory target, so that fetch, LW_MEM and SW_MEM stall until the responder completes the access.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words. Power of two, ≥ 2.
- WAIT_CYCLES, 2: wait states between acceptance and response. Range 0..15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- req  in  1  access request; requester holds addr/we/wdata stable until `ready`.
- we  in  1  1 = write (memrw), 0 = read.
- addr  in  32  byte address.
- wdata  in  32  write data.
- rdata  out  32  read data; valid only while `ready`=1 and `we`=0 was captured.
- ready  out  1  one-cycle completion pulse.
- err  out  1  asserted together with `ready` when the access faulted.
- busy  out  1  high in WAIT and RESP.

## Operation
- States:
  - IDLE: default.
  - WAIT: counting wait states.
  - RESP: issuing `ready`.
- Transitions:
  - IDLE: if `req`=1, capture addr, we, wdata into request registers and load the counter with WAIT_CYCLES-1. Go to WAIT, or directly to RESP if WAIT_CYCLES=0. If `req`=0, stay in IDLE.
  - WAIT: decrement the counter. When the counter is 0, go to RESP.
  - RESP: always go to IDLE.
- The counter is $clog2(WAIT_CYCLES+1) bits wide, minimum 1 bit. It never wraps.
- Word index = captured addr[2 +: $clog2(DEPTH_WORDS)].
- Fault condition: captured addr[1:0] ≠ 0, or captured addr ≥ DEPTH_WORDS*4 (compared on the full 32 bits).
- Write: performed at the clock edge that ends the RESP cycle, only if the captured `we`=1 and there is no fault.
- Read: the array is read when entering RESP and the result is registered into `rdata`, so `rdata` is stable for the whole RESP cycle. A faulted read returns `rdata`=0.
- Outside RESP, `rdata` holds its last value. The requester must not use it.
- `err` is asserted only in RESP, and only if the fault condition holds. A faulted write leaves the array unchanged.
- Input changes during WAIT/RESP are ignored, because the captured values are used. A `req` drop during WAIT does not abort the access; the response still occurs.
- `req` still high in RESP is not a new request. The next access can be accepted no earlier than the cycle after RESP, in IDLE.
- Array contents are not reset and are undefined until written.

## Timing
- Reset values: state=IDLE, ready=0, err=0, busy=0, rdata=0, counter=0, request registers=0.
- `req` sampled high in IDLE during cycle t gives `ready`=1 in cycle t+1+WAIT_CYCLES.
  - WAIT_CYCLES=2: ready at t+3.
  - WAIT_CYCLES=0: ready at t+1.
- Minimum period between back-to-back accesses = WAIT_CYCLES+2 cycles (RESP followed by one IDLE cycle).
- A write becomes visible to a read accepted in any later cycle.
- Reset asserted mid-WAIT or in RESP:
  - The FSM returns to IDLE immediately and the access is dropped.
  - No `ready` is issued and no array write occurs, because the write edge is suppressed under reset.
- Outputs ready, err, busy and rdata are all registered. They are not combinational from inputs.

## Test plan
- Write then read, WAIT_CYCLES=2: write addr=0x10, wdata=0xDEADBEEF.
  - Required: ready at t+3 with err=0.
  - Then read addr=0x10: ready at t+3 with rdata=0xDEADBEEF, err=0. busy is high for exactly 3 cycles per access.
- Misaligned access: write addr=0x22, wdata=0x12345678.
  - Required: ready with err=1.
  - A subsequent read of 0x20 returns the prior value (not 0x12345678), err=0.
- Out-of-range access, DEPTH_WORDS=1024: read addr=0x1000.
  - Required: ready with err=1, rdata=0.
  - Then addr=0xFFC: err=0.
- WAIT_CYCLES=0, back-to-back: `req` held high continuously, alternating write 0x4←0xA5A5A5A5 and read 0x4.
  - Required: ready every 2nd cycle.
  - The read returns 0xA5A5A5A5.
- Request deasserted mid-wait: `req` drops to 0 after acceptance; addr changes to 0x8 during WAIT.
  - Required: ready still at t+1+WAIT_CYCLES.
  - The original address is served.
- Reset mid-operation: assert rst during WAIT of a write to 0x30 ← 0x55.
  - Required: ready, err and busy go to 0 immediately; no ready pulse follows.
  - A later read of 0x30 returns the pre-existing value.
